// File: rtl/start_seq_ctrl_pkg.sv
// Shared types for the starting-line controller: the FSM state enumeration.
// Widths are derived from module parameters, so the package carries no localparams.
package start_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEDS  = 3'd1,
    DELAY = 3'd2,
    GO    = 3'd3,
    FAULT = 3'd4
  } ty_START_STATE;

endpackage

// File: rtl/start_seq_ctrl_if.sv
// Control/status bundle between the starting-line controller and its environment.
// "master" drives the requests (timebase, buttons, delay); "slave" is the controller.
interface start_seq_ctrl_if #(
  parameter int NUM_LEDS = 10,
  parameter int DELAY_W  = 10,
  parameter int REACT_W  = 16
);

  logic                i_tick;
  logic                i_trigger;
  logic                i_abort;
  logic                i_react;
  logic [DELAY_W-1:0]  i_delay;
  logic                o_enPRBS;
  logic [NUM_LEDS-1:0] o_leds;
  logic                o_go;
  logic                o_falseStart;
  logic                o_reactValid;
  logic [REACT_W-1:0]  o_reactTicks;

  modport master (
    output i_tick, i_trigger, i_abort, i_react, i_delay,
    input  o_enPRBS, o_leds, o_go, o_falseStart, o_reactValid, o_reactTicks
  );

  modport slave (
    input  i_tick, i_trigger, i_abort, i_react, i_delay,
    output o_enPRBS, o_leds, o_go, o_falseStart, o_reactValid, o_reactTicks
  );

endinterface

// File: rtl/start_seq_ctrl_led_sequencer.sv
// Light-tree shift register: each step lights one more LED from bit 0 upward,
// and o_allOn flags that the whole tree is lit (further steps are ignored).
module led_sequencer #(
  parameter int NUM_LEDS = 10
) (
  input  logic                i_clk,
  input  logic                i_arst,
  input  logic                i_clear,
  input  logic                i_step,
  output logic [NUM_LEDS-1:0] o_leds,
  output logic                o_allOn
);

  localparam int CNT_W = $clog2(NUM_LEDS + 1);

  logic [CNT_W-1:0] led_cnt;

  assign o_allOn = (led_cnt == CNT_W'(NUM_LEDS));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_arst || i_clear) begin
      o_leds  <= '0;
      led_cnt <= '0;
    end else if (i_step && !o_allOn) begin
      o_leds  <= {o_leds[NUM_LEDS-2:0], 1'b1};
      led_cnt <= led_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/start_seq_ctrl.sv
// Starting-line controller: LED countdown, random hold, GO and reaction timing.
// Optional build macro START_SEQ_FLASH_EN makes the LEDs flash on a false start.
module start_seq_ctrl
  import start_seq_pkg::*;
#(
  parameter int NUM_LEDS = 10,
  parameter int DELAY_W  = 10,
  parameter int REACT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_arst,
  start_seq_ctrl_if.slave   bus
);

  // Last count before the counter would saturate at all-ones.
  localparam logic [REACT_W-1:0] REACT_LAST = ~REACT_W'(1);

  ty_START_STATE       state;
  logic [DELAY_W-1:0]  delay_q;
  logic [REACT_W-1:0]  react_cnt;
  logic [REACT_W-1:0]  react_ticks;
  logic                react_valid;

  logic [NUM_LEDS-1:0] seq_leds;
  logic                seq_all_on;
  logic                seq_clear;
  logic                seq_step;
  logic [NUM_LEDS-1:0] fault_leds;
  logic [NUM_LEDS-1:0] leds;

  // The tree only holds a pattern while counting down; everywhere else it is kept empty
  // so that a fresh LEDS entry always starts from zero lit LEDs.
  assign seq_clear = !((state == LEDS) || (state == DELAY));
  assign seq_step  = (state == LEDS) && bus.i_tick && !bus.i_react && !bus.i_abort;

  led_sequencer #(.NUM_LEDS(NUM_LEDS)) u_led_sequencer (
    .i_clk   (i_clk),
    .i_arst  (i_arst),
    .i_clear (seq_clear),
    .i_step  (seq_step),
    .o_leds  (seq_leds),
    .o_allOn (seq_all_on)
  );

  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      state       <= IDLE;
      delay_q     <= '0;
      react_cnt   <= '0;
      react_ticks <= '0;
      react_valid <= 1'b0;
    end else begin
      react_valid <= 1'b0;
      if (bus.i_abort) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (bus.i_trigger) begin
              state   <= LEDS;
              delay_q <= bus.i_delay;
            end
          end
          LEDS: begin
            if (bus.i_react)     state <= FAULT;
            else if (seq_all_on) state <= DELAY;
          end
          DELAY: begin
            if (bus.i_react) begin
              state <= FAULT;
            end else if (bus.i_tick) begin
              if (delay_q == '0) begin
                state     <= GO;
                react_cnt <= '0;
              end else begin
                delay_q <= delay_q - DELAY_W'(1);
              end
            end
          end
          GO: begin
            // A press in the same cycle as a tick reports the count before that tick.
            if (bus.i_react) begin
              state       <= IDLE;
              react_ticks <= react_cnt;
              react_valid <= 1'b1;
            end else if (bus.i_tick) begin
              if (react_cnt == REACT_LAST) begin
                state       <= IDLE;
                react_ticks <= '1;
                react_valid <= 1'b1;
              end else begin
                react_cnt <= react_cnt + REACT_W'(1);
              end
            end
          end
          FAULT: begin
            if (bus.i_trigger) state <= IDLE;
          end
          // NOTE: unused encodings recover to IDLE instead of locking up.
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef START_SEQ_FLASH_EN
  logic fault_on;

  // Lit on FAULT entry, then toggled by each tick while the fault is shown.
  always_ff @(posedge i_clk) begin
    if (i_arst || (state != FAULT)) fault_on <= 1'b1;
    else if (bus.i_tick)            fault_on <= ~fault_on;
  end

  assign fault_leds = {NUM_LEDS{fault_on}};
`else
  assign fault_leds = '1;
`endif

  // LED drive is a state-selected choice between registered patterns.
  always_comb begin
    // NOTE: default first so no path through the case leaves leds unassigned (no latch).
    leds = '0;
    case (state)
      LEDS, DELAY: leds = seq_leds;
      FAULT:       leds = fault_leds;
      default:     leds = '0;
    endcase
  end

  assign bus.o_leds       = leds;
  assign bus.o_enPRBS     = (state == IDLE);
  assign bus.o_go         = (state == GO);
  assign bus.o_falseStart = (state == FAULT);
  assign bus.o_reactValid = react_valid;
  assign bus.o_reactTicks = react_ticks;

endmodule

// File: tb/tb_start_seq_ctrl.sv
// Self-checking bench for start_seq_ctrl: directed scenarios plus random stimulus,
// every cycle compared against a phase/counter reference model.
module tb_start_seq_ctrl;

  localparam int NL = 4;
  localparam int DW = 4;
  localparam int RW = 4;

  logic clk = 1'b0;
  logic arst = 1'b0;
  always #5 clk = ~clk;

  start_seq_ctrl_if #(.NUM_LEDS(NL), .DELAY_W(DW), .REACT_W(RW)) bus ();

  start_seq_ctrl #(.NUM_LEDS(NL), .DELAY_W(DW), .REACT_W(RW)) dut (
    .i_clk  (clk),
    .i_arst (arst),
    .bus    (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int tick_phase = 0;
  int valid_seen = 0;
  bit last_tick;
  logic [DW-1:0] cur_delay = '0;

  // Reference model: run phase plus plain integer counters.
  typedef enum {M_IDLE, M_LEDS, M_DELAY, M_GO, M_FAULT} m_phase_e;
  m_phase_e m_phase = M_IDLE;
  int m_lit = 0;        // LEDs lit so far
  int m_wait = 0;       // DELAY ticks still needed before GO
  int m_rcnt = 0;       // ticks elapsed in GO
  int m_out = 0;        // reported reaction time
  bit m_valid = 0;
  bit m_flash = 1;

  task automatic model_step(input bit rst, tick, trig, abort, react, input int dly);
    if (rst) begin
      m_phase = M_IDLE; m_lit = 0; m_out = 0; m_valid = 0; m_flash = 1;
      return;
    end
    m_valid = 0;
    if (abort) begin
      m_phase = M_IDLE; m_lit = 0;
      return;
    end
    case (m_phase)
      M_IDLE: if (trig) begin m_phase = M_LEDS; m_lit = 0; m_wait = dly + 1; end
      M_LEDS: begin
        if (react)            begin m_phase = M_FAULT; m_flash = 1; end
        else if (m_lit == NL) m_phase = M_DELAY;
        else if (tick)        m_lit++;
      end
      M_DELAY: begin
        if (react) begin m_phase = M_FAULT; m_flash = 1; end
        else if (tick) begin
          m_wait--;
          if (m_wait == 0) begin m_phase = M_GO; m_rcnt = 0; end
        end
      end
      M_GO: begin
        if (react) begin m_phase = M_IDLE; m_out = m_rcnt; m_valid = 1; end
        else if (tick) begin
          if (m_rcnt + 1 == (1 << RW) - 1) begin
            m_phase = M_IDLE; m_out = (1 << RW) - 1; m_valid = 1;
          end else m_rcnt++;
        end
      end
      M_FAULT: begin
        if (tick) m_flash = !m_flash;
        if (trig) m_phase = M_IDLE;
      end
      default: m_phase = M_IDLE;
    endcase
  endtask

  function automatic logic [11:0] model_out();
    logic [NL-1:0] l;
    l = '0;
    if (m_phase == M_LEDS || m_phase == M_DELAY) l = NL'((1 << m_lit) - 1);
    if (m_phase == M_FAULT) begin
`ifdef START_SEQ_FLASH_EN
      l = m_flash ? '1 : '0;
`else
      l = '1;
`endif
    end
    return {m_phase == M_IDLE, l, m_phase == M_GO, m_phase == M_FAULT, m_valid, RW'(m_out)};
  endfunction

  function automatic logic [11:0] dut_out();
    return {bus.o_enPRBS, bus.o_leds, bus.o_go, bus.o_falseStart, bus.o_reactValid, bus.o_reactTicks};
  endfunction

  // Drives one clock cycle and scores every output against the model.
  task automatic drive_cycle(input string tag, input bit rst, tick, trig, abort, react);
    logic [11:0] exp_v;
    logic [11:0] act_v;
    arst = rst;
    bus.i_tick = tick; bus.i_trigger = trig; bus.i_abort = abort;
    bus.i_react = react; bus.i_delay = cur_delay;
    @(posedge clk);
    model_step(rst, tick, trig, abort, react, int'(cur_delay));
    #1;
    exp_v = model_out();
    act_v = dut_out();
    n_tests++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s @%0t outputs {prbs,leds,go,fs,valid,ticks} got %h want %h", tag, $time, act_v, exp_v);
    end
    if (bus.o_reactValid === 1'b1) valid_seen++;
  endtask

  // One cycle on the fixed timebase: a tick every third cycle.
  task automatic run(input string tag, input bit trig, abort, react);
    last_tick = (tick_phase == 2);
    tick_phase = (tick_phase + 1) % 3;
    drive_cycle(tag, 1'b0, last_tick, trig, abort, react);
  endtask

  task automatic wait_go(input string tag, output int ticks);
    int k;
    k = 0; ticks = 0;
    while (bus.o_go !== 1'b1 && k < 300) begin
      run(tag, 0, 0, 0);
      if (last_tick) ticks++;
      k++;
    end
    if (bus.o_go !== 1'b1) begin
      n_tests++; n_fail++;
      $display("FAIL %s_wait_go go got %b want 1 within 300 cycles", tag, bus.o_go);
    end
  endtask

  task automatic go_ticks(input string tag, input int n);
    int c, k;
    bit g;
    c = 0; k = 0;
    while (c < n && k < 100) begin
      g = bus.o_go;
      run(tag, 0, 0, 0);
      if (g && last_tick) c++;
      k++;
    end
  endtask

  task automatic test_reset();
    drive_cycle("reset", 1, 0, 0, 0, 0);
    drive_cycle("reset", 1, 1, 1, 0, 1);
    n_tests++;
    if (dut_out() !== 12'h800) begin
      n_fail++; $display("FAIL reset_values got %h want 800", dut_out());
    end
  endtask

  task automatic test_nominal();
    int t, v0;
    cur_delay = 4'd2;
    run("nom_trig", 1, 0, 0);
    wait_go("nom", t);
    n_tests++;
    if (t != NL + 2 + 1) begin n_fail++; $display("FAIL nom_ticks_to_go got %0d want %0d", t, NL + 3); end
    go_ticks("nom_go", 5);
    v0 = valid_seen;
    run("nom_react", 0, 0, 1);
    n_tests++;
    if (bus.o_reactValid !== 1'b1 || bus.o_reactTicks !== 4'd5) begin
      n_fail++; $display("FAIL nom_react valid/ticks got %b/%0d want 1/5", bus.o_reactValid, bus.o_reactTicks);
    end
    run("nom_after", 0, 0, 0);
    n_tests++;
    if (valid_seen - v0 != 1 || bus.o_enPRBS !== 1'b1) begin
      n_fail++; $display("FAIL nom_pulse pulses/prbs got %0d/%b want 1/1", valid_seen - v0, bus.o_enPRBS);
    end
  endtask

  task automatic test_zero_delay();
    int t;
    cur_delay = 4'd0;
    run("zero_trig", 1, 0, 0);
    wait_go("zero", t);
    n_tests++;
    if (t != NL + 1) begin n_fail++; $display("FAIL zero_ticks_to_go got %0d want %0d", t, NL + 1); end
    run("zero_abort", 0, 1, 0);
  endtask

  task automatic test_false_start();
    int k, v0;
    cur_delay = DW'($urandom);
    run("fs_trig", 1, 0, 0);
    k = 0;
    while (bus.o_leds !== 4'b0011 && k < 50) begin run("fs_leds", 0, 0, 0); k++; end
    v0 = valid_seen;
    run("fs_react", 0, 0, 1);
    n_tests++;
    if (bus.o_falseStart !== 1'b1 || bus.o_leds !== 4'hF || bus.o_go !== 1'b0) begin
      n_fail++; $display("FAIL fs_entry fs/leds/go got %b/%h/%b want 1/f/0", bus.o_falseStart, bus.o_leds, bus.o_go);
    end
    for (int i = 0; i < 7; i++) run("fs_hold", 0, 0, 0);
    n_tests++;
    if (valid_seen != v0 || bus.o_falseStart !== 1'b1) begin
      n_fail++; $display("FAIL fs_hold pulses/fs got %0d/%b want 0/1", valid_seen - v0, bus.o_falseStart);
    end
    run("fs_trig_out", 1, 0, 0);
    run("fs_idle", 0, 0, 0);
    n_tests++;
    if (bus.o_enPRBS !== 1'b1 || bus.o_falseStart !== 1'b0 || bus.o_leds !== 4'h0) begin
      n_fail++; $display("FAIL fs_exit prbs/fs/leds got %b/%b/%h want 1/0/0", bus.o_enPRBS, bus.o_falseStart, bus.o_leds);
    end
  endtask

  task automatic test_timeout();
    int t, n, k, v0;
    bit g;
    cur_delay = DW'($urandom_range(0, 3));
    run("to_trig", 1, 0, 0);
    wait_go("to", t);
    v0 = valid_seen; n = 0; k = 0;
    while (k < 200) begin
      g = bus.o_go;
      run("to_go", 0, 0, 0);
      if (g && last_tick) n++;
      k++;
      if (bus.o_reactValid === 1'b1) break;
    end
    n_tests++;
    if (n != 15 || bus.o_reactTicks !== 4'hF || bus.o_enPRBS !== 1'b1 || valid_seen != v0 + 1) begin
      n_fail++;
      $display("FAIL timeout ticks/report/prbs/pulses got %0d/%h/%b/%0d want 15/f/1/1", n, bus.o_reactTicks, bus.o_enPRBS, valid_seen - v0);
    end
  endtask

  task automatic test_abort_and_same_cycle();
    int k, t;
    cur_delay = 4'd3;
    run("ab_trig", 1, 0, 0);
    k = 0;
    while (bus.o_leds !== 4'hF && k < 50) begin run("ab_leds", 0, 0, 0); k++; end
    for (int i = 0; i < 4; i++) run("ab_delay", 0, 0, 0);
    n_tests++;
    if (bus.o_go !== 1'b0 || bus.o_leds !== 4'hF) begin
      n_fail++; $display("FAIL ab_in_delay go/leds got %b/%h want 0/f", bus.o_go, bus.o_leds);
    end
    run("ab_abort", 0, 1, 0);
    n_tests++;
    if (bus.o_enPRBS !== 1'b1 || bus.o_leds !== 4'h0 || bus.o_reactValid !== 1'b0) begin
      n_fail++; $display("FAIL ab_abort prbs/leds/valid got %b/%h/%b want 1/0/0", bus.o_enPRBS, bus.o_leds, bus.o_reactValid);
    end
    cur_delay = 4'd1;
    run("sc_trig", 1, 0, 0);
    wait_go("sc", t);
    go_ticks("sc_go", 3);
    k = 0;
    while (tick_phase != 2 && k < 5) begin run("sc_wait", 0, 0, 0); k++; end
    run("sc_react_tick", 0, 0, 1);
    n_tests++;
    if (bus.o_reactValid !== 1'b1 || bus.o_reactTicks !== 4'd3) begin
      n_fail++; $display("FAIL same_cycle valid/ticks got %b/%0d want 1/3", bus.o_reactValid, bus.o_reactTicks);
    end
    run("ab_trig_idle", 1, 1, 0);
    run("ab_idle", 0, 0, 0);
    n_tests++;
    if (bus.o_enPRBS !== 1'b1 || bus.o_leds !== 4'h0 || bus.o_go !== 1'b0) begin
      n_fail++; $display("FAIL abort_trigger prbs/leds/go got %b/%h/%b want 1/0/0", bus.o_enPRBS, bus.o_leds, bus.o_go);
    end
  endtask

  task automatic test_reset_mid_go();
    int t;
    cur_delay = 4'd0;
    run("rg_trig", 1, 0, 0);
    wait_go("rg", t);
    for (int i = 0; i < 4; i++) run("rg_go", 0, 0, 0);
    drive_cycle("rg_reset", 1, 0, 0, 0, 0);
    n_tests++;
    if (dut_out() !== 12'h800) begin
      n_fail++; $display("FAIL reset_mid_go got %h want 800", dut_out());
    end
    run("rg_idle", 0, 0, 0);
  endtask

  task automatic test_random();
    int react_div;
    for (int seg = 0; seg < 6; seg++) begin
      react_div = (seg % 2 == 0) ? 6 : 80;
      for (int i = 0; i < 500; i++) begin
        cur_delay = DW'($urandom);
        drive_cycle("random",
                    $urandom_range(0, 299) == 0,
                    $urandom_range(0, 2) == 0,
                    $urandom_range(0, 3) == 0,
                    $urandom_range(0, 39) == 0,
                    $urandom_range(0, react_div - 1) == 0);
      end
    end
  endtask

  initial begin
    bus.i_tick = 1'b0; bus.i_trigger = 1'b0; bus.i_abort = 1'b0;
    bus.i_react = 1'b0; bus.i_delay = '0;
    test_reset();
    test_nominal();
    test_zero_delay();
    test_false_start();
    test_timeout();
    test_abort_and_same_cycle();
    test_reset_mid_go();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
